// File: rtl/branch_predictor_if.sv
// Fetch/execute side bundle of the branch predictor: lookup port,
// resolved-branch update port, table clear and statistics outputs.
interface branch_predictor_if #(
  parameter int STAT_W = 16
);
  // fetch-stage lookup
  logic [31:0]       lookup_pc;
  logic              hit;
  logic              pred_taken;
  logic [31:0]       pred_target;

  // execute-stage resolution
  logic              update_en;
  logic [31:0]       update_pc;
  logic              update_taken;
  logic [31:0]       update_target;
  logic              upd_pred_taken;
  logic [31:0]       upd_pred_target;
  logic              mispredict;

  // table control and statistics
  logic              clear;
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] mis_count;

  // pipeline side: drives PCs and resolved outcomes, consumes predictions
  modport master (
    output lookup_pc,
    output update_en,
    output update_pc,
    output update_taken,
    output update_target,
    output upd_pred_taken,
    output upd_pred_target,
    output clear,
    input  hit,
    input  pred_taken,
    input  pred_target,
    input  mispredict,
    input  br_count,
    input  mis_count
  );

  // predictor side
  modport slave (
    input  lookup_pc,
    input  update_en,
    input  update_pc,
    input  update_taken,
    input  update_target,
    input  upd_pred_taken,
    input  upd_pred_target,
    input  clear,
    output hit,
    output pred_taken,
    output pred_target,
    output mispredict,
    output br_count,
    output mis_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction
// counters. Lookup is combinational for the fetch stage; one resolved
// branch per cycle trains the table on the next clock edge. Saturating
// branch/mispredict counters are kept for performance monitoring.
module branch_predictor #(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [1:0] CNT_ALLOC = 2'b10;

  // Next value of a 2-bit direction counter, saturating at both ends.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (cnt == 2'd3) nxt = 2'd3;
      else             nxt = cnt + 2'd1;
    end else begin
      if (cnt == 2'd0) nxt = 2'd0;
      else             nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

  // Table storage
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];

  // Statistics
  logic [STAT_W-1:0]  r_br_count;
  logic [STAT_W-1:0]  r_mis_count;

  // Lookup path
  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;
  logic               w_lk_taken;
  logic [31:0]        w_lk_target;

  // Update path
  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic               w_up_train;
  logic               w_up_alloc;
  logic [1:0]         w_up_cnt;
  logic               w_mispredict;

  // Byte offset of both PCs carries no information for word-aligned code.
  logic               w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = &{1'b0, bp.lookup_pc[1:0], bp.update_pc[1:0]};

  assign w_lk_idx = bp.lookup_pc[IDX_W+1:2];
  assign w_lk_tag = bp.lookup_pc[31:IDX_W+2];
  assign w_up_idx = bp.update_pc[IDX_W+1:2];
  assign w_up_tag = bp.update_pc[31:IDX_W+2];

  // Fetch-side prediction: taken target only when the entry hits and the
  // counter is in one of the two taken states, otherwise fall through.
  always_comb begin
    w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    w_lk_taken  = w_lk_hit && r_cnt[w_lk_idx][1];
    if (w_lk_taken) begin
      w_lk_target = r_target[w_lk_idx];
    end else begin
      w_lk_target = bp.lookup_pc + 32'd4;
    end
  end

  // Decide what the resolved branch does to its table entry: train an
  // existing entry, allocate on a taken miss, or leave the table alone.
  always_comb begin
    w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    w_up_cnt   = cnt_next(r_cnt[w_up_idx], bp.update_taken);
    w_up_train = 1'b0;
    w_up_alloc = 1'b0;
    if (bp.update_en && !bp.clear) begin
      if (w_up_hit) begin
        w_up_train = 1'b1;
      end else if (bp.update_taken) begin
        w_up_alloc = 1'b1;
      end else begin
        w_up_train = 1'b0;
      end
    end else begin
      w_up_train = 1'b0;
    end
  end

  // Mispredict depends only on what the pipeline carried down versus the
  // actual outcome; a not-taken branch never has a meaningful target.
  always_comb begin
    w_mispredict = 1'b0;
    if (bp.update_en) begin
      if (bp.upd_pred_taken != bp.update_taken) begin
        w_mispredict = 1'b1;
      end else if (bp.update_taken && (bp.upd_pred_target != bp.update_target)) begin
        w_mispredict = 1'b1;
      end else begin
        w_mispredict = 1'b0;
      end
    end else begin
      w_mispredict = 1'b0;
    end
  end

  // Table state: reset/clear invalidate everything; clear takes priority
  // over a same-cycle update, which is dropped.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= {TAG_W{1'b0}};
        r_target[i] <= 32'd0;
        r_cnt[i]    <= CNT_INIT;
      end
    end else if (bp.clear) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= CNT_INIT;
      end
    end else if (w_up_alloc) begin
      r_valid[w_up_idx]  <= 1'b1;
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= bp.update_target;
      r_cnt[w_up_idx]    <= CNT_ALLOC;
    end else if (w_up_train) begin
      r_cnt[w_up_idx] <= w_up_cnt;
      if (bp.update_taken) begin
        r_target[w_up_idx] <= bp.update_target;
      end
    end
  end

  // Saturating statistics; only nRST clears them, table clear does not.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_br_count  <= {STAT_W{1'b0}};
      r_mis_count <= {STAT_W{1'b0}};
    end else begin
      if (bp.update_en && (r_br_count != STAT_MAX)) begin
        r_br_count <= r_br_count + STAT_W'(1);
      end
      if (w_mispredict && (r_mis_count != STAT_MAX)) begin
        r_mis_count <= r_mis_count + STAT_W'(1);
      end
    end
  end

  assign bp.hit         = w_lk_hit;
  assign bp.pred_taken  = w_lk_taken;
  assign bp.pred_target = w_lk_target;
  assign bp.mispredict  = w_mispredict;
  assign bp.br_count    = r_br_count;
  assign bp.mis_count   = r_mis_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, STAT_W=16).
module tb_branch_predictor;

  logic CLK;
  logic nRST;
  int   errors;
  int   checks;

  branch_predictor_if #(.STAT_W(16)) bp_if ();

  branch_predictor #(
    .ENTRIES (16),
    .CNT_INIT(2'b01),
    .STAT_W  (16)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bp  (bp_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One resolved branch presented for exactly one clock edge.
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic ptaken, input logic [31:0] ptgt);
    bp_if.update_pc       = pc;
    bp_if.update_taken    = taken;
    bp_if.update_target   = tgt;
    bp_if.upd_pred_taken  = ptaken;
    bp_if.upd_pred_target = ptgt;
    bp_if.update_en       = 1'b1;
    @(posedge CLK);
    #1;
    bp_if.update_en       = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bp_if.clear           = 1'b0;
    bp_if.lookup_pc       = 32'h40;
    bp_if.update_pc       = 32'h40;
    bp_if.update_taken    = 1'b1;
    bp_if.update_target   = 32'h100;
    bp_if.upd_pred_taken  = 1'b0;
    bp_if.upd_pred_target = 32'h0;
    bp_if.update_en       = 1'b1;
    #2;
    checks++; if (bp_if.hit !== 1'b0) begin errors++; $display("FAIL rst_hit got=%0h exp=0", bp_if.hit); end
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got=%0h exp=0", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h44) begin errors++; $display("FAIL rst_pred_target got=%0h exp=44", bp_if.pred_target); end
    checks++; if (bp_if.br_count !== 16'h0) begin errors++; $display("FAIL rst_br_count got=%0h exp=0", bp_if.br_count); end
    checks++; if (bp_if.mis_count !== 16'h0) begin errors++; $display("FAIL rst_mis_count got=%0h exp=0", bp_if.mis_count); end
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL rst_mispredict got=%0h exp=1", bp_if.mispredict); end
    #20;
    bp_if.update_en = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checks++; if (bp_if.br_count !== 16'h0) begin errors++; $display("FAIL rst_br_after got=%0h exp=0", bp_if.br_count); end
  endtask

  task automatic test_allocate();
    bp_if.lookup_pc       = 32'h40;
    bp_if.update_pc       = 32'h40;
    bp_if.update_taken    = 1'b1;
    bp_if.update_target   = 32'h100;
    bp_if.upd_pred_taken  = 1'b0;
    bp_if.upd_pred_target = 32'h44;
    bp_if.update_en       = 1'b1;
    #1;
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got=%0h exp=1", bp_if.mispredict); end
    checks++; if (bp_if.hit !== 1'b0) begin errors++; $display("FAIL alloc_pre_hit got=%0h exp=0", bp_if.hit); end
    @(posedge CLK);
    #1;
    bp_if.update_en = 1'b0;
    #1;
    checks++; if (bp_if.hit !== 1'b1) begin errors++; $display("FAIL alloc_hit got=%0h exp=1", bp_if.hit); end
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken got=%0h exp=1", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h100) begin errors++; $display("FAIL alloc_target got=%0h exp=100", bp_if.pred_target); end
    checks++; if (bp_if.mis_count !== 16'd1) begin errors++; $display("FAIL alloc_mis_count got=%0d exp=1", bp_if.mis_count); end
    checks++; if (bp_if.br_count !== 16'd1) begin errors++; $display("FAIL alloc_br_count got=%0d exp=1", bp_if.br_count); end
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL alloc_mispredict_idle got=%0h exp=0", bp_if.mispredict); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    bp_if.lookup_pc = 32'h40;
    #1;
    checks++; if (bp_if.br_count !== 16'd4) begin errors++; $display("FAIL sat_br_count got=%0d exp=4", bp_if.br_count); end
    checks++; if (bp_if.mis_count !== 16'd1) begin errors++; $display("FAIL sat_mis_count got=%0d exp=1", bp_if.mis_count); end
    upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    #1;
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL sat_cnt2_taken got=%0h exp=1", bp_if.pred_taken); end
    upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    #1;
    checks++; if (bp_if.hit !== 1'b1) begin errors++; $display("FAIL sat_cnt1_hit got=%0h exp=1", bp_if.hit); end
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL sat_cnt1_taken got=%0h exp=0", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h44) begin errors++; $display("FAIL sat_cnt1_target got=%0h exp=44", bp_if.pred_target); end
    checks++; if (bp_if.mis_count !== 16'd3) begin errors++; $display("FAIL sat_mis_count2 got=%0d exp=3", bp_if.mis_count); end
    checks++; if (bp_if.br_count !== 16'd6) begin errors++; $display("FAIL sat_br_count2 got=%0d exp=6", bp_if.br_count); end
  endtask

  task automatic test_alias();
    upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
    bp_if.lookup_pc = 32'h40;
    #1;
    checks++; if (bp_if.hit !== 1'b0) begin errors++; $display("FAIL alias_old_hit got=%0h exp=0", bp_if.hit); end
    bp_if.lookup_pc = 32'h80;
    #1;
    checks++; if (bp_if.hit !== 1'b1) begin errors++; $display("FAIL alias_new_hit got=%0h exp=1", bp_if.hit); end
    checks++; if (bp_if.pred_target !== 32'h300) begin errors++; $display("FAIL alias_new_target got=%0h exp=300", bp_if.pred_target); end
    upd(32'hC0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++; if (bp_if.hit !== 1'b1) begin errors++; $display("FAIL alias_nt_miss_keeps got=%0h exp=1", bp_if.hit); end
    checks++; if (bp_if.br_count !== 16'd8) begin errors++; $display("FAIL alias_br_count got=%0d exp=8", bp_if.br_count); end
    checks++; if (bp_if.mis_count !== 16'd4) begin errors++; $display("FAIL alias_mis_count got=%0d exp=4", bp_if.mis_count); end
  endtask

  task automatic test_clear();
    logic [31:0] pcs [4];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h48; pcs[3] = 32'h80;
    upd(32'h44, 1'b1, 32'h500, 1'b0, 32'h48);
    bp_if.clear = 1'b1;
    upd(32'h48, 1'b1, 32'h600, 1'b0, 32'h4C);
    bp_if.clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bp_if.lookup_pc = pcs[i];
      #1;
      checks++; if (bp_if.hit !== 1'b0) begin errors++; $display("FAIL clear_hit pc=%0h got=%0h exp=0", pcs[i], bp_if.hit); end
    end
    bp_if.lookup_pc = 32'h44;
    #1;
    checks++; if (bp_if.pred_target !== 32'h48) begin errors++; $display("FAIL clear_target got=%0h exp=48", bp_if.pred_target); end
    checks++; if (bp_if.br_count !== 16'd10) begin errors++; $display("FAIL clear_br_count got=%0d exp=10", bp_if.br_count); end
    checks++; if (bp_if.mis_count !== 16'd6) begin errors++; $display("FAIL clear_mis_count got=%0d exp=6", bp_if.mis_count); end
    upd(32'h48, 1'b1, 32'h600, 1'b0, 32'h4C);
    bp_if.lookup_pc = 32'h48;
    #1;
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL clear_realloc_taken got=%0h exp=1", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h600) begin errors++; $display("FAIL clear_realloc_target got=%0h exp=600", bp_if.pred_target); end
  endtask

  task automatic test_mispredict_cases();
    logic [31:0] ptgt [5];
    logic [31:0] atgt [5];
    logic        ptk  [5];
    logic        atk  [5];
    logic        en   [5];
    logic        exp  [5];
    ptk[0]=1'b1; atk[0]=1'b1; ptgt[0]=32'h200; atgt[0]=32'h204; en[0]=1'b1; exp[0]=1'b1;
    ptk[1]=1'b1; atk[1]=1'b1; ptgt[1]=32'h200; atgt[1]=32'h200; en[1]=1'b1; exp[1]=1'b0;
    ptk[2]=1'b1; atk[2]=1'b0; ptgt[2]=32'h200; atgt[2]=32'h200; en[2]=1'b1; exp[2]=1'b1;
    ptk[3]=1'b0; atk[3]=1'b0; ptgt[3]=32'h200; atgt[3]=32'h204; en[3]=1'b1; exp[3]=1'b0;
    ptk[4]=1'b0; atk[4]=1'b1; ptgt[4]=32'h200; atgt[4]=32'h204; en[4]=1'b0; exp[4]=1'b0;
    bp_if.update_pc = 32'h48;
    for (int i = 0; i < 5; i++) begin
      bp_if.upd_pred_taken  = ptk[i];
      bp_if.update_taken    = atk[i];
      bp_if.upd_pred_target = ptgt[i];
      bp_if.update_target   = atgt[i];
      bp_if.update_en       = en[i];
      #1;
      checks++; if (bp_if.mispredict !== exp[i]) begin errors++; $display("FAIL mispredict_case%0d got=%0h exp=%0h", i, bp_if.mispredict, exp[i]); end
    end
    bp_if.update_en = 1'b0;
    bp_if.lookup_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (bp_if.pred_target !== 32'h0) begin errors++; $display("FAIL wrap_target got=%0h exp=0", bp_if.pred_target); end
  endtask

  task automatic test_stat_saturation();
    bp_if.update_pc       = 32'h4C;
    bp_if.update_taken    = 1'b0;
    bp_if.update_target   = 32'h0;
    bp_if.upd_pred_taken  = 1'b0;
    bp_if.upd_pred_target = 32'h0;
    bp_if.update_en       = 1'b1;
    repeat (65524) @(posedge CLK);
    #1;
    bp_if.update_en = 1'b0;
    checks++; if (bp_if.br_count !== 16'hFFFF) begin errors++; $display("FAIL stat_br_max got=%0h exp=ffff", bp_if.br_count); end
    checks++; if (bp_if.mis_count !== 16'd7) begin errors++; $display("FAIL stat_mis_before got=%0d exp=7", bp_if.mis_count); end
    upd(32'h4C, 1'b0, 32'h0, 1'b1, 32'h0);
    checks++; if (bp_if.br_count !== 16'hFFFF) begin errors++; $display("FAIL stat_br_sat got=%0h exp=ffff", bp_if.br_count); end
    checks++; if (bp_if.mis_count !== 16'd8) begin errors++; $display("FAIL stat_mis_after got=%0d exp=8", bp_if.mis_count); end
  endtask

  task automatic test_reset_mid_update();
    bp_if.update_pc       = 32'h40;
    bp_if.update_taken    = 1'b1;
    bp_if.update_target   = 32'h700;
    bp_if.upd_pred_taken  = 1'b0;
    bp_if.upd_pred_target = 32'h44;
    bp_if.update_en       = 1'b1;
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    bp_if.update_en = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    bp_if.lookup_pc = 32'h40;
    #1;
    checks++; if (bp_if.hit !== 1'b0) begin errors++; $display("FAIL rstmid_hit40 got=%0h exp=0", bp_if.hit); end
    bp_if.lookup_pc = 32'h48;
    #1;
    checks++; if (bp_if.hit !== 1'b0) begin errors++; $display("FAIL rstmid_hit48 got=%0h exp=0", bp_if.hit); end
    checks++; if (bp_if.br_count !== 16'h0) begin errors++; $display("FAIL rstmid_br got=%0h exp=0", bp_if.br_count); end
    checks++; if (bp_if.mis_count !== 16'h0) begin errors++; $display("FAIL rstmid_mis got=%0h exp=0", bp_if.mis_count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_clear();
    test_mispredict_cases();
    test_stat_saturation();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
